// File: rtl/load_store_buffer.sv
// In-order load/store buffer: queues memory ops, snoops the CDB for outstanding operands
// and hands one request at a time to the memory stage, waiting for its done pulse.
module load_store_buffer #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [2:0]  TAG_BASE = 3'd4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        issue_valid,
    input  logic        issue_store,
    input  logic [3:0]  issue_reg,
    input  logic [15:0] issue_imm,
    input  logic [15:0] issue_base_val,
    input  logic [2:0]  issue_base_tag,
    input  logic [15:0] issue_data_val,
    input  logic [2:0]  issue_data_tag,
    output logic        issue_ready,
    input  logic        cdb_valid,
    input  logic [2:0]  cdb_tag,
    input  logic [15:0] cdb_value,
    output logic        key_mem,
    output logic [42:0] instruction,
    input  logic        done
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StWait
    } state_e;

    state_e            state_q, state_d;
    logic [42:0]       instr_q, instr_d;
    logic [PtrW-1:0]   head_q, head_d;
    logic [PtrW-1:0]   tail_q, tail_d;
    logic [CntW-1:0]   count_q, count_d;

    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [DEPTH-1:0]  store_q, store_d;
    logic [3:0]        reg_id_q   [DEPTH];
    logic [3:0]        reg_id_d   [DEPTH];
    logic [15:0]       imm_q      [DEPTH];
    logic [15:0]       imm_d      [DEPTH];
    logic [15:0]       base_val_q [DEPTH];
    logic [15:0]       base_val_d [DEPTH];
    logic [2:0]        base_tag_q [DEPTH];
    logic [2:0]        base_tag_d [DEPTH];
    logic [15:0]       data_val_q [DEPTH];
    logic [15:0]       data_val_d [DEPTH];
    logic [2:0]        data_tag_q [DEPTH];
    logic [2:0]        data_tag_d [DEPTH];

    logic              push;
    logic              pop;
    logic              cdb_live;
    logic              base_hit;
    logic              data_hit;
    logic              head_ready;
    logic [2:0]        head_tag;
    logic [15:0]       head_addr;
    logic [42:0]       head_instr;

    assign issue_ready = (count_q != CntW'(DEPTH));
    assign push        = issue_valid && issue_ready;
    assign key_mem     = (state_q == StSend);
    assign instruction = instr_q;

    // Tag 0 marks an operand with no producer, so a broadcast on tag 0 must never match.
    assign cdb_live = cdb_valid && (cdb_tag != 3'd0);
    assign base_hit = cdb_live && (issue_base_tag == cdb_tag);
    assign data_hit = cdb_live && (issue_data_tag == cdb_tag);

    assign head_tag   = TAG_BASE + 3'(head_q);
    assign head_addr  = base_val_q[head_q] + imm_q[head_q];
    assign head_ready = valid_q[head_q] && (base_tag_q[head_q] == 3'd0) &&
                        (!store_q[head_q] || (data_tag_q[head_q] == 3'd0));

    always_comb begin
        head_instr = {head_tag, 1'b1, store_q[head_q], 2'b00, reg_id_q[head_q], 32'h0};
        if (store_q[head_q]) begin
            head_instr[31:0] = {head_addr, data_val_q[head_q]};
        end else begin
            head_instr[31:0] = {16'h0000, head_addr};
        end
    end

    // Entry storage: CDB snoop first, then the new tail entry, then retirement of the head.
    always_comb begin
        valid_d    = valid_q;
        store_d    = store_q;
        reg_id_d   = reg_id_q;
        imm_d      = imm_q;
        base_val_d = base_val_q;
        base_tag_d = base_tag_q;
        data_val_d = data_val_q;
        data_tag_d = data_tag_q;

        if (cdb_live) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_q[i] && (base_tag_q[i] == cdb_tag)) begin
                    base_val_d[i] = cdb_value;
                    base_tag_d[i] = 3'd0;
                end
                if (valid_q[i] && (data_tag_q[i] == cdb_tag)) begin
                    data_val_d[i] = cdb_value;
                    data_tag_d[i] = 3'd0;
                end
            end
        end

        if (push) begin
            valid_d[tail_q]    = 1'b1;
            store_d[tail_q]    = issue_store;
            reg_id_d[tail_q]   = issue_reg;
            imm_d[tail_q]      = issue_imm;
            base_val_d[tail_q] = base_hit ? cdb_value : issue_base_val;
            base_tag_d[tail_q] = base_hit ? 3'd0 : issue_base_tag;
            // Loads never wait on store data, so their data tag is forced clear.
            data_val_d[tail_q] = (issue_store && data_hit) ? cdb_value : issue_data_val;
            data_tag_d[tail_q] = (issue_store && !data_hit) ? issue_data_tag : 3'd0;
        end

        if (pop) begin
            valid_d[head_q] = 1'b0;
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) begin
            tail_d = tail_q + 1'b1;
        end
        if (pop) begin
            head_d = head_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        pop     = 1'b0;
        case (state_q)
            StIdle: begin
                instr_d = '0;
                if ((count_q != '0) && head_ready) begin
                    state_d = StSend;
                    instr_d = head_instr;
                end
            end
            StSend: begin
                state_d = StWait;
            end
            StWait: begin
                if (done) begin
                    state_d = StIdle;
                    instr_d = '0;
                    pop     = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                instr_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            instr_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            store_q <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
            store_q <= store_d;
        end
    end

    // Payload is qualified by valid_q, so it needs no reset.
    always_ff @(posedge clock) begin
        reg_id_q   <= reg_id_d;
        imm_q      <= imm_d;
        base_val_q <= base_val_d;
        base_tag_q <= base_tag_d;
        data_val_q <= data_val_d;
        data_tag_q <= data_tag_d;
    end

endmodule

// File: tb/tb_load_store_buffer.sv
// Self-checking bench for load_store_buffer: directed scenarios plus a randomized run
// against a queue-based model of dispatch, CDB capture and in-order issue.
module tb_load_store_buffer;

    localparam int DEPTH   = 4;
    localparam int TagBase = 4;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        issue_valid = 1'b0;
    logic        issue_store = 1'b0;
    logic [3:0]  issue_reg = '0;
    logic [15:0] issue_imm = '0;
    logic [15:0] issue_base_val = '0;
    logic [2:0]  issue_base_tag = '0;
    logic [15:0] issue_data_val = '0;
    logic [2:0]  issue_data_tag = '0;
    logic        issue_ready;
    logic        cdb_valid = 1'b0;
    logic [2:0]  cdb_tag = '0;
    logic [15:0] cdb_value = '0;
    logic        key_mem;
    logic [42:0] instruction;
    logic        done = 1'b0;

    load_store_buffer #(
        .DEPTH    (DEPTH),
        .TAG_BASE (3'd4)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .issue_valid    (issue_valid),
        .issue_store    (issue_store),
        .issue_reg      (issue_reg),
        .issue_imm      (issue_imm),
        .issue_base_val (issue_base_val),
        .issue_base_tag (issue_base_tag),
        .issue_data_val (issue_data_val),
        .issue_data_tag (issue_data_tag),
        .issue_ready    (issue_ready),
        .cdb_valid      (cdb_valid),
        .cdb_tag        (cdb_tag),
        .cdb_value      (cdb_value),
        .key_mem        (key_mem),
        .instruction    (instruction),
        .done           (done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        st;
        logic [3:0]  rg;
        logic [15:0] imm;
        logic [15:0] bv;
        logic [2:0]  bt;
        logic [15:0] dv;
        logic [2:0]  dt;
        logic [2:0]  tag;
    } op_t;

    // Model: queue of buffered ops, memory-handshake phase (0 idle, 1 request, 2 waiting).
    op_t         q[$];
    int          tail_idx;
    int          exp_st;
    logic [42:0] held;
    logic        exp_key;
    logic [42:0] exp_ins;
    logic        exp_rdy;

    logic [42:0] sent_q[$];
    int          sent_cyc[$];
    int          cyc;
    int          checks;
    int          errors;

    function automatic logic op_ready(op_t o);
        return (o.bt == 3'd0) && (!o.st || (o.dt == 3'd0));
    endfunction

    function automatic logic [42:0] instr_of(op_t o);
        logic [15:0] a;
        a = o.bv + o.imm;
        return {o.tag, 1'b1, o.st, 2'b00, o.rg, (o.st ? a : 16'h0000), (o.st ? o.dv : a)};
    endfunction

    function automatic logic [42:0] sent_at(int idx);
        if (idx < sent_q.size()) return sent_q[idx];
        return '0;
    endfunction

    // Samples outputs at the falling edge, drives this cycle's inputs and advances the model.
    task automatic tick(input logic iv, input logic st, input logic [3:0] rg,
                        input logic [15:0] imm, input logic [15:0] bv, input logic [2:0] bt,
                        input logic [15:0] dv, input logic [2:0] dt, input logic cv,
                        input logic [2:0] ct, input logic [15:0] cval, input logic dn);
        op_t  o;
        logic pop;
        logic full;
        @(negedge clock);
        cyc++;
        exp_key = (exp_st == 1);
        exp_ins = (exp_st == 0) ? '0 : held;
        exp_rdy = (q.size() != DEPTH);
        if (key_mem === 1'b1) begin
            sent_q.push_back(instruction);
            sent_cyc.push_back(cyc);
        end
        issue_valid = iv; issue_store = st; issue_reg = rg; issue_imm = imm;
        issue_base_val = bv; issue_base_tag = bt; issue_data_val = dv; issue_data_tag = dt;
        cdb_valid = cv; cdb_tag = ct; cdb_value = cval; done = dn;

        full = (q.size() == DEPTH);
        pop  = 1'b0;
        if (exp_st == 0) begin
            if (q.size() > 0 && op_ready(q[0])) begin
                exp_st = 1;
                held   = instr_of(q[0]);
            end
        end else if (exp_st == 1) begin
            exp_st = 2;
        end else if (dn) begin
            pop    = 1'b1;
            exp_st = 0;
        end
        if (cv && ct != 3'd0) begin
            foreach (q[i]) begin
                if (q[i].bt == ct) begin q[i].bv = cval; q[i].bt = 3'd0; end
                if (q[i].dt == ct) begin q[i].dv = cval; q[i].dt = 3'd0; end
            end
        end
        if (iv && !full) begin
            o.st = st; o.rg = rg; o.imm = imm;
            o.bv = bv; o.bt = bt;
            o.dv = dv; o.dt = st ? dt : 3'd0;
            if (cv && ct != 3'd0 && o.bt == ct) begin o.bv = cval; o.bt = 3'd0; end
            if (cv && ct != 3'd0 && o.dt == ct) begin o.dv = cval; o.dt = 3'd0; end
            o.tag    = 3'(TagBase + tail_idx);
            tail_idx = (tail_idx + 1) % DEPTH;
            q.push_back(o);
        end
        if (pop) void'(q.pop_front());
    endtask

    task automatic idle(input logic auto_done);
        tick(1'b0, 1'b0, '0, '0, '0, '0, '0, '0, 1'b0, '0, '0, auto_done && (exp_st == 2));
    endtask

    task automatic do_reset;
        @(negedge clock);
        reset_n = 1'b0;
        issue_valid = 1'b0; cdb_valid = 1'b0; done = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        q.delete();
        exp_st = 0; tail_idx = 0; held = '0;
    endtask

    task automatic test_reset;
        #1;
        checks++; if (key_mem !== 1'b0) begin errors++; $display("FAIL reset_key_mem got %b exp 0", key_mem); end
        checks++; if (instruction !== 43'h0) begin errors++; $display("FAIL reset_instruction got %h exp 0", instruction); end
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_issue_ready got %b exp 1", issue_ready); end
        do_reset();
    endtask

    task automatic test_load;
        int          n0;
        int          cd;
        logic [42:0] exp;
        do_reset();
        n0 = sent_q.size();
        tick(1'b1, 1'b0, 4'h3, 16'h0004, 16'h0010, 3'd0, 16'h0, 3'd0, 1'b0, '0, '0, 1'b0);
        cd = cyc;
        for (int k = 0; k < 10; k++) idle(1'b1);
        exp = {3'd4, 1'b1, 1'b0, 2'b00, 4'h3, 16'h0000, 16'h0014};
        checks++; if (sent_q.size() - n0 != 1) begin errors++; $display("FAIL load_pulses got %0d exp 1", sent_q.size() - n0); end
        checks++; if (sent_at(n0) !== exp) begin errors++; $display("FAIL load_instruction got %h exp %h", sent_at(n0), exp); end
        checks++; if (sent_q.size() > n0 && sent_cyc[n0] != cd + 2) begin errors++; $display("FAIL load_latency got %0d exp %0d", sent_cyc[n0] - cd, 2); end
        checks++; if (instruction !== 43'h0 || key_mem !== 1'b0) begin errors++; $display("FAIL load_idle_after got %h/%b exp 0/0", instruction, key_mem); end
    endtask

    task automatic test_store_cdb;
        int          n0;
        int          cc;
        logic [42:0] w;
        logic [42:0] exp;
        do_reset();
        n0 = sent_q.size();
        tick(1'b1, 1'b1, 4'h2, 16'h0000, 16'h1111, 3'd1, 16'hBEEF, 3'd0, 1'b0, '0, '0, 1'b0);
        idle(1'b0);
        checks++; if (key_mem !== 1'b0) begin errors++; $display("FAIL store_early_key got %b exp 0", key_mem); end
        tick(1'b0, 1'b0, '0, '0, '0, '0, '0, '0, 1'b1, 3'd1, 16'h0200, 1'b0);
        cc = cyc;
        for (int k = 0; k < 10; k++) idle(1'b1);
        w   = sent_at(n0);
        exp = {3'd4, 1'b1, 1'b1, 2'b00, 4'h2, 16'h0200, 16'hBEEF};
        checks++; if (sent_q.size() - n0 != 1) begin errors++; $display("FAIL store_pulses got %0d exp 1", sent_q.size() - n0); end
        checks++; if (sent_q.size() > n0 && sent_cyc[n0] != cc + 2) begin errors++; $display("FAIL store_after_capture got cycle %0d exp %0d", sent_cyc[n0], cc + 2); end
        checks++; if (w[31:0] !== {16'h0200, 16'hBEEF} || w[38] !== 1'b1) begin errors++; $display("FAIL store_fields got %h exp %h", w, exp); end
        checks++; if (w !== exp) begin errors++; $display("FAIL store_instruction got %h exp %h", w, exp); end
    endtask

    task automatic test_fill;
        int          n0;
        logic        popped;
        logic [42:0] w;
        int          exp_tag[5] = '{4, 5, 6, 7, 4};
        int          exp_reg[5] = '{0, 1, 2, 3, 5};
        do_reset();
        n0 = sent_q.size();
        for (int k = 0; k < DEPTH; k++) begin
            tick(1'b1, 1'b0, 4'(k), 16'h0001, 16'(k * 16), 3'd0, 16'h0, 3'd0, 1'b0, '0, '0, 1'b0);
        end
        tick(1'b1, 1'b0, 4'hF, 16'h0001, 16'h0F00, 3'd0, 16'h0, 3'd0, 1'b0, '0, '0, 1'b0);
        checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL fill_full_ready got %b exp 0", issue_ready); end
        popped = 1'b0;
        for (int k = 0; k < 10 && !popped; k++) begin
            popped = (exp_st == 2);
            idle(1'b1);
            if (popped) begin
                checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL fill_pop_same_cycle got %b exp 0", issue_ready); end
            end
        end
        checks++; if (!popped) begin errors++; $display("FAIL fill_no_wait got 0 exp 1"); end
        tick(1'b1, 1'b0, 4'h5, 16'h0001, 16'h0050, 3'd0, 16'h0, 3'd0, 1'b0, '0, '0, 1'b0);
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_after_pop got %b exp 1", issue_ready); end
        for (int k = 0; k < 40; k++) idle(1'b1);
        checks++; if (sent_q.size() - n0 != 5) begin errors++; $display("FAIL fill_count got %0d exp 5", sent_q.size() - n0); end
        for (int k = 0; k < 5; k++) begin
            w = sent_at(n0 + k);
            checks++;
            if (w[42:40] !== 3'(exp_tag[k]) || w[35:32] !== 4'(exp_reg[k])) begin
                errors++;
                $display("FAIL fill_order_%0d got tag %0d reg %0d exp tag %0d reg %0d", k, w[42:40], w[35:32], exp_tag[k], exp_reg[k]);
            end
        end
    endtask

    task automatic test_addr_wrap;
        int          n0;
        logic [42:0] w;
        do_reset();
        n0 = sent_q.size();
        tick(1'b1, 1'b0, 4'h1, 16'h0005, 16'hFFFE, 3'd0, 16'h0, 3'd0, 1'b0, '0, '0, 1'b0);
        for (int k = 0; k < 8; k++) idle(1'b1);
        w = sent_at(n0);
        checks++; if (w[15:0] !== 16'h0003 || w[31:16] !== 16'h0000) begin errors++; $display("FAIL addr_wrap got %h exp 0003", w[31:0]); end
    endtask

    task automatic test_head_block;
        int          n0;
        logic [42:0] w0;
        logic [42:0] w1;
        do_reset();
        n0 = sent_q.size();
        tick(1'b1, 1'b0, 4'hA, 16'h0001, 16'h0000, 3'd2, 16'h0, 3'd0, 1'b0, '0, '0, 1'b0);
        tick(1'b1, 1'b0, 4'hB, 16'h0002, 16'h0100, 3'd0, 16'h0, 3'd0, 1'b0, '0, '0, 1'b0);
        for (int k = 0; k < 6; k++) idle(1'b1);
        checks++; if (sent_q.size() != n0) begin errors++; $display("FAIL block_no_issue got %0d exp 0", sent_q.size() - n0); end
        tick(1'b0, 1'b0, '0, '0, '0, '0, '0, '0, 1'b1, 3'd2, 16'h3000, 1'b0);
        for (int k = 0; k < 16; k++) idle(1'b1);
        w0 = sent_at(n0);
        w1 = sent_at(n0 + 1);
        checks++; if (w0[42:40] !== 3'd4 || w0[15:0] !== 16'h3001) begin errors++; $display("FAIL block_first got %h exp tag 4 addr 3001", w0); end
        checks++; if (w1[42:40] !== 3'd5 || w1[15:0] !== 16'h0102) begin errors++; $display("FAIL block_second got %h exp tag 5 addr 0102", w1); end
    endtask

    task automatic test_reset_mid;
        int n0;
        do_reset();
        tick(1'b1, 1'b0, 4'h7, 16'h0001, 16'h0040, 3'd0, 16'h0, 3'd0, 1'b0, '0, '0, 1'b0);
        for (int k = 0; k < 10 && exp_st != 2; k++) idle(1'b0);
        checks++; if (exp_st != 2) begin errors++; $display("FAIL mid_reach_wait got %0d exp 2", exp_st); end
        @(posedge clock);
        #2;
        checks++; if (instruction !== held || key_mem !== 1'b0) begin errors++; $display("FAIL mid_wait_state got %h/%b exp %h/0", instruction, key_mem, held); end
        reset_n = 1'b0;
        #1;
        checks++; if (key_mem !== 1'b0 || instruction !== 43'h0) begin errors++; $display("FAIL mid_reset_outputs got %b/%h exp 0/0", key_mem, instruction); end
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_ready got %b exp 1", issue_ready); end
        @(negedge clock);
        reset_n = 1'b1;
        q.delete();
        exp_st = 0; tail_idx = 0; held = '0;
        n0 = sent_q.size();
        tick(1'b0, 1'b0, '0, '0, '0, '0, '0, '0, 1'b0, '0, '0, 1'b1);
        for (int k = 0; k < 6; k++) idle(1'b0);
        checks++; if (sent_q.size() != n0 || instruction !== 43'h0) begin errors++; $display("FAIL mid_abandon got %0d/%h exp 0/0", sent_q.size() - n0, instruction); end
        // Buffer must be empty: exactly DEPTH blocked dispatches are needed to fill it.
        for (int k = 0; k < DEPTH; k++) begin
            tick(1'b1, 1'b0, 4'(k), '0, '0, 3'd1, '0, '0, 1'b0, '0, '0, 1'b0);
            checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL mid_count_%0d got %b exp 1", k, issue_ready); end
        end
        idle(1'b0);
        checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL mid_count_full got %b exp 0", issue_ready); end
    endtask

    task automatic test_random;
        logic        iv, st, cv, dn;
        logic [2:0]  bt, dt, ct;
        do_reset();
        for (int n = 0; n < 800; n++) begin
            iv = ($urandom_range(0, 2) != 0);
            st = $urandom_range(0, 1) != 0;
            bt = ($urandom_range(0, 1) != 0) ? 3'd0 : 3'($urandom_range(1, 3));
            dt = ($urandom_range(0, 1) != 0) ? 3'd0 : 3'($urandom_range(1, 3));
            cv = $urandom_range(0, 1) != 0;
            ct = 3'($urandom_range(1, 3));
            dn = $urandom_range(0, 1) != 0;
            tick(iv, st, 4'($urandom), 16'($urandom), 16'($urandom), bt, 16'($urandom), dt,
                 cv, ct, 16'($urandom), dn);
            checks++; if (key_mem !== exp_key) begin errors++; $display("FAIL rand_key_mem cyc %0d got %b exp %b", cyc, key_mem, exp_key); end
            checks++; if (instruction !== exp_ins) begin errors++; $display("FAIL rand_instruction cyc %0d got %h exp %h", cyc, instruction, exp_ins); end
            checks++; if (issue_ready !== exp_rdy) begin errors++; $display("FAIL rand_issue_ready cyc %0d got %b exp %b", cyc, issue_ready, exp_rdy); end
        end
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0;
        exp_st = 0; tail_idx = 0; held = '0;
        test_reset();
        test_load();
        test_store_cdb();
        test_fill();
        test_addr_wrap();
        test_head_block();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

endmodule
